pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised, elastic inter-stage pipeline register for the RISC-V core. It replaces fixed hold-on-stall stage registers with a valid/ready handshake and a two-entry skid buffer, so a downstream stall is absorbed without a combinational ready path. It provides a synchronous flush that squashes in-flight entries. Control bits are masked to a configurable bubble value whenever no valid instruction is presented, and saturating stall/flush counters support pipeline debugging.

## Interface
Parameters:
- DATA_W, default 128: payload width (operands, immediate, PC, register addresses).
- CTRL_W, default 16: control-bit width (write enables, branch/jump flags, ALU op).
- CTRL_BUBBLE, default 0 (CTRL_W bits): control value presented when out_valid is 0.
- CNT_W, default 16: width of the performance counters.

Ports:
- clk  in  1  rising-edge clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream holds a valid instruction.
- in_ready  out  1  stage accepts this cycle.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control bits.
- out_valid  out  1  valid instruction presented downstream.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  payload of the head entry.
- out_ctrl  out  CTRL_W  head control bits, or CTRL_BUBBLE when out_valid is 0.
- flush  in  1  synchronous squash of all entries.
- stall  in  1  hazard-unit freeze: no transfer in or out.
- clr_cnt  in  1  synchronous clear of both counters.
- occupancy  out  2  number of valid entries (0..2).
- stall_cnt  out  CNT_W  saturating count of stalled cycles.
- flush_cnt  out  CNT_W  saturating count of effective flushes.

## Operation
- Storage: main entry M (head) and skid entry S. State is EMPTY, ONE (M valid) or FULL (M and S valid).
- Handshake signals:
  - in_ready = !flush && !stall && state != FULL.
  - out_valid = M valid && !flush && !stall.
  - Input fire = in_valid && in_ready. Output fire = out_valid && out_ready.
- out_data always drives M data. out_ctrl = out_valid ? M ctrl : CTRL_BUBBLE.
- Transitions (flush has priority over all others):
  - Any state with flush: go to EMPTY and zero M and S data/ctrl. An input offered in the same cycle is dropped.
  - EMPTY, input fire: go to ONE, load M from the input.
  - ONE, input fire and output fire: stay in ONE, load M from the input.
  - ONE, output fire only: go to EMPTY.
  - ONE, input fire only: go to FULL, load S from the input.
  - FULL, output fire: go to ONE, M takes S. in_ready is 0 in FULL, so there is no simultaneous input.
  - Otherwise: hold.
- stall with flush: flush wins. stall alone holds state and data and presents a bubble downstream.
- stall_cnt increments in cycles with stall=1, flush=0 and state != EMPTY.
- flush_cnt increments in cycles with flush=1 and state != EMPTY.
- Both counters saturate at 2^CNT_W-1. clr_cnt zeroes them and wins over an increment in the same cycle.

## Timing
- Latency is 1 cycle from input fire to out_valid when the stage is empty and there is no stall.
- Throughput is 1 per cycle with out_ready held high.
- in_ready and out_valid depend combinationally only on local state, flush and stall. in_ready never depends on out_ready.
- Reset (asynchronous assert, deassert synchronised externally):
  - State EMPTY, M and S zero, counters zero.
  - out_valid 0, out_ctrl CTRL_BUBBLE, out_data 0, occupancy 0.
  - in_ready is 1 once reset_n=1 and stall=0.
- Reset mid-operation discards all entries immediately. It does not count as a flush.
- Flush takes effect in the asserting cycle: out_valid is forced 0 combinationally, and entries are empty on the next edge.

## Structure
- Package pipe_pkg holds the state enum (EMPTY/ONE/FULL), the occupancy encoding and the CNT_W default.
- Sub-module pipe_sat_counter (CNT_W, inc, clr) is instantiated twice for stall_cnt and flush_cnt.
- Stage instances (IF_ID, ID_EX, EX_MEM, MEM_WB) pack their fields into in_data/in_ctrl at the instantiation site.

## Test plan
- Reset, then in_data=0xA5, in_valid=1, out_ready=1 -> next cycle out_valid=1, out_data=0xA5, occupancy=1.
- out_ready=0, send 0x11, 0x22, 0x33 -> 0x11 and 0x22 accepted, in_ready=0 on the third, occupancy=2. Then out_ready=1 -> 0x11 and 0x22 drain in order, no loss.
- FULL with stall=1 for 4 cycles -> out_valid=0, out_ctrl=CTRL_BUBBLE, state held, stall_cnt=4.
- FULL with flush=1 and stall=1 -> next cycle occupancy=0, out_valid=0, flush_cnt=1. Flush while EMPTY -> flush_cnt unchanged.
- CNT_W=2, stall for 6 cycles -> stall_cnt saturates at 3. clr_cnt with stall=1 -> stall_cnt=0.
- Assert reset_n=0 asynchronously mid-stream while FULL -> outputs go to reset values immediately, no clock edge required.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline stage register: occupancy state,
// its 2-bit encoding on the occupancy port, and the default counter width.
package pipe_pkg;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } pipe_state_e;

  localparam logic [1:0] OccEmpty = 2'd0;
  localparam logic [1:0] OccOne   = 2'd1;
  localparam logic [1:0] OccFull  = 2'd2;

  localparam int unsigned CntWDefault = 16;

  function automatic logic [1:0] occupancy_of(pipe_state_e state);
    unique case (state)
      StEmpty: occupancy_of = OccEmpty;
      StOne:   occupancy_of = OccOne;
      StFull:  occupancy_of = OccFull;
      default: occupancy_of = OccEmpty;
    endcase
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with a synchronous clear that beats increment.
module pipe_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic inter-stage register: valid/ready handshake, two-entry skid buffer,
// synchronous flush, bubble-masked control and saturating stall/flush counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W      = 128,
  parameter int unsigned       CTRL_W      = 16,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
  parameter int unsigned       CNT_W       = CntWDefault
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  input  logic              stall,
  input  logic              clr_cnt,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  pipe_state_e       state_q, state_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;

  logic in_fire;
  logic out_fire;
  logic stall_inc;
  logic flush_inc;

  // Handshake depends only on local state, flush and stall; never on out_ready.
  always_comb begin
    in_ready  = !flush && !stall && (state_q != StFull);
    out_valid = (state_q != StEmpty) && !flush && !stall;
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
  end

  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    m_ctrl_d = m_ctrl_q;
    s_data_d = s_data_q;
    s_ctrl_d = s_ctrl_q;
    if (flush) begin
      state_d  = StEmpty;
      m_data_d = '0;
      m_ctrl_d = '0;
      s_data_d = '0;
      s_ctrl_d = '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_fire) begin
            state_d  = StOne;
            m_data_d = in_data;
            m_ctrl_d = in_ctrl;
          end
        end
        StOne: begin
          if (in_fire && out_fire) begin
            m_data_d = in_data;
            m_ctrl_d = in_ctrl;
          end else if (out_fire) begin
            state_d = StEmpty;
          end else if (in_fire) begin
            state_d  = StFull;
            s_data_d = in_data;
            s_ctrl_d = in_ctrl;
          end
        end
        StFull: begin
          if (out_fire) begin
            state_d  = StOne;
            m_data_d = s_data_q;
            m_ctrl_d = s_ctrl_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StEmpty;
      m_data_q <= '0;
      m_ctrl_q <= '0;
      s_data_q <= '0;
      s_ctrl_q <= '0;
    end else begin
      state_q  <= state_d;
      m_data_q <= m_data_d;
      m_ctrl_q <= m_ctrl_d;
      s_data_q <= s_data_d;
      s_ctrl_q <= s_ctrl_d;
    end
  end

  assign out_data  = m_data_q;
  assign out_ctrl  = out_valid ? m_ctrl_q : CTRL_BUBBLE;
  assign occupancy = occupancy_of(state_q);

  // Only cycles that actually hold or squash something are counted.
  assign stall_inc = stall && !flush && (state_q != StEmpty);
  assign flush_inc = flush && (state_q != StEmpty);

  pipe_sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .inc    (stall_inc),
    .clr    (clr_cnt),
    .cnt    (stall_cnt)
  );

  pipe_sat_counter #(
    .CNT_W(CNT_W)
  ) u_flush_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .inc    (flush_inc),
    .clr    (clr_cnt),
    .cnt    (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg; a second instance with CNT_W=2 shares
// all inputs and is used for counter saturation.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] BUB = 4'hA;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid, out_ready, flush, stall, clr_cnt;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    occupancy;
  logic [15:0]   stall_cnt, flush_cnt;

  logic          s_in_ready, s_out_valid;
  logic [DW-1:0] s_out_data;
  logic [CW-1:0] s_out_ctrl;
  logic [1:0]    s_occupancy;
  logic [1:0]    s_stall_cnt, s_flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE(BUB), .CNT_W(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ctrl(out_ctrl), .flush(flush), .stall(stall),
    .clr_cnt(clr_cnt), .occupancy(occupancy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_stage_reg #(
    .DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE(BUB), .CNT_W(2)
  ) dut_small (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .out_ctrl(s_out_ctrl), .flush(flush), .stall(stall),
    .clr_cnt(clr_cnt), .occupancy(s_occupancy), .stall_cnt(s_stall_cnt),
    .flush_cnt(s_flush_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    stall = 1'b0; clr_cnt = 1'b0; in_data = '0; in_ctrl = '0;
    #12;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_tests++; if (out_ctrl !== BUB) begin n_fail++;
      $display("FAIL reset_out_ctrl: got %h want %h", out_ctrl, BUB); end
    n_tests++; if (out_data !== 8'h00) begin n_fail++;
      $display("FAIL reset_out_data: got %h want 00", out_data); end
    n_tests++; if (occupancy !== 2'd0) begin n_fail++;
      $display("FAIL reset_occ: got %0d want 0", occupancy); end
    n_tests++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin n_fail++;
      $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
    reset_n = 1'b1;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    step();
  endtask

  task automatic test_latency();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hA5; in_ctrl = 4'h3;
    step();
    in_valid = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ctrl !== 4'h3) begin
      n_fail++; $display("FAIL latency_out: got v=%b d=%h c=%h want v=1 d=a5 c=3",
                         out_valid, out_data, out_ctrl); end
    n_tests++; if (occupancy !== 2'd1) begin n_fail++;
      $display("FAIL latency_occ: got %0d want 1", occupancy); end
    step();
    n_tests++; if (occupancy !== 2'd0 || out_ctrl !== BUB) begin n_fail++;
      $display("FAIL latency_drain: got occ=%0d c=%h want occ=0 c=%h",
               occupancy, out_ctrl, BUB); end
  endtask

  task automatic test_skid();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h11; in_ctrl = 4'h1;
    step();
    in_data = 8'h22; in_ctrl = 4'h2;
    step();
    in_data = 8'h33; in_ctrl = 4'h3;
    #1;
    n_tests++; if (in_ready !== 1'b0 || occupancy !== 2'd2) begin n_fail++;
      $display("FAIL skid_full: got rdy=%b occ=%0d want rdy=0 occ=2", in_ready, occupancy); end
    step();
    n_tests++; if (occupancy !== 2'd2 || out_data !== 8'h11) begin n_fail++;
      $display("FAIL skid_hold: got occ=%0d d=%h want occ=2 d=11", occupancy, out_data); end
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    n_tests++; if (out_valid !== 1'b1 || out_data !== 8'h11 || out_ctrl !== 4'h1) begin
      n_fail++; $display("FAIL skid_first: got v=%b d=%h c=%h want v=1 d=11 c=1",
                         out_valid, out_data, out_ctrl); end
    step();
    n_tests++; if (out_data !== 8'h22 || out_ctrl !== 4'h2 || occupancy !== 2'd1) begin
      n_fail++; $display("FAIL skid_second: got d=%h c=%h occ=%0d want d=22 c=2 occ=1",
                         out_data, out_ctrl, occupancy); end
    step();
    n_tests++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin n_fail++;
      $display("FAIL skid_empty: got occ=%0d v=%b want occ=0 v=0", occupancy, out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h40; in_ctrl = 4'h4;
    step();
    n_tests++; if (out_data !== 8'h40 || in_ready !== 1'b1) begin n_fail++;
      $display("FAIL b2b_first: got d=%h rdy=%b want d=40 rdy=1", out_data, in_ready); end
    in_data = 8'h41; in_ctrl = 4'h5;
    step();
    n_tests++; if (out_data !== 8'h41 || out_ctrl !== 4'h5 || occupancy !== 2'd1) begin
      n_fail++; $display("FAIL b2b_second: got d=%h c=%h occ=%0d want d=41 c=5 occ=1",
                         out_data, out_ctrl, occupancy); end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_stall();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h55; in_ctrl = 4'h6;
    step();
    in_data = 8'h66; in_ctrl = 4'h7;
    step();
    in_valid = 1'b0; clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0; stall = 1'b1; out_ready = 1'b1;
    #1;
    n_tests++; if (out_valid !== 1'b0 || out_ctrl !== BUB || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL stall_bubble: got v=%b c=%h rdy=%b want v=0 c=%h rdy=0",
                         out_valid, out_ctrl, in_ready, BUB); end
    repeat (4) step();
    stall = 1'b0; out_ready = 1'b0;
    #1;
    n_tests++; if (stall_cnt !== 16'd4) begin n_fail++;
      $display("FAIL stall_cnt: got %0d want 4", stall_cnt); end
    n_tests++; if (occupancy !== 2'd2 || out_data !== 8'h55 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL stall_held: got occ=%0d d=%h v=%b want occ=2 d=55 v=1",
                         occupancy, out_data, out_valid); end
  endtask

  task automatic test_flush();
    flush = 1'b1; stall = 1'b1; in_valid = 1'b1; in_data = 8'h99;
    #1;
    n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin n_fail++;
      $display("FAIL flush_comb: got v=%b rdy=%b want 0/0", out_valid, in_ready); end
    step();
    flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
    #1;
    n_tests++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_data !== 8'h00) begin
      n_fail++; $display("FAIL flush_empty: got occ=%0d v=%b d=%h want occ=0 v=0 d=00",
                         occupancy, out_valid, out_data); end
    n_tests++; if (flush_cnt !== 16'd1 || stall_cnt !== 16'd4) begin n_fail++;
      $display("FAIL flush_cnt: got f=%0d s=%0d want f=1 s=4", flush_cnt, stall_cnt); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    n_tests++; if (flush_cnt !== 16'd1) begin n_fail++;
      $display("FAIL flush_idle: got %0d want 1", flush_cnt); end
  endtask

  task automatic test_saturation();
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h77; in_ctrl = 4'h8;
    step();
    in_valid = 1'b0; stall = 1'b1;
    repeat (6) step();
    n_tests++; if (s_stall_cnt !== 2'd3 || stall_cnt !== 16'd6) begin n_fail++;
      $display("FAIL sat_cnt: got small=%0d wide=%0d want small=3 wide=6",
               s_stall_cnt, stall_cnt); end
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    #1;
    n_tests++; if (s_stall_cnt !== 2'd0 || stall_cnt !== 16'd0) begin n_fail++;
      $display("FAIL sat_clr: got small=%0d wide=%0d want 0/0", s_stall_cnt, stall_cnt); end
    stall = 1'b0;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hC1; in_ctrl = 4'h9;
    step();
    n_tests++; if (occupancy !== 2'd2 || out_data !== 8'h77) begin n_fail++;
      $display("FAIL areset_fill: got occ=%0d d=%h want occ=2 d=77", occupancy, out_data); end
    in_valid = 1'b0; stall = 1'b1;
    step();
    stall = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    n_tests++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_data !== 8'h00) begin
      n_fail++; $display("FAIL areset_state: got occ=%0d v=%b d=%h want occ=0 v=0 d=00",
                         occupancy, out_valid, out_data); end
    n_tests++; if (out_ctrl !== BUB || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      n_fail++; $display("FAIL areset_misc: got c=%h s=%0d f=%0d want c=%h s=0 f=0",
                         out_ctrl, stall_cnt, flush_cnt, BUB); end
    #3;
    reset_n = 1'b1;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++;
      $display("FAIL areset_ready: got %b want 1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_skid();
    test_back_to_back();
    test_stall();
    test_flush();
    test_saturation();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
